// File: rtl/wb_stage.sv
// wb_stage: MEM/WB latch, 32x32 GPR file and HI/LO pair with combinational read ports.
// Define WB_BYPASS_EN to forward the latched write-back bundle onto the read outputs.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall_i,
    input  logic [4:0]  mem_rw_i,
    input  logic        mem_wreg_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        re1_i,
    input  logic        re2_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [4:0]  wb_rw_o,
    output logic        wb_wreg_o,
    output logic [31:0] wb_wdata_o,
    output logic        wb_whilo_o,
    output logic [31:0] wb_hi_o,
    output logic [31:0] wb_lo_o
);
    logic [4:0]  wb_rw_q, wb_rw_d;
    logic        wb_wreg_q, wb_wreg_d, wb_whilo_q, wb_whilo_d;
    logic [31:0] wb_wdata_q, wb_wdata_d, wb_hi_q, wb_hi_d, wb_lo_q, wb_lo_d;
    logic [31:0] hi_q, lo_q;
    logic [31:0] gpr_q [0:31];
    logic        byp1, byp2, byp_hl;

    // WB stall holds the latch; a MEM-only stall injects a bubble
    always_comb begin
        wb_rw_d    = stall_i[1] ? wb_rw_q    : stall_i[0] ? '0 : mem_rw_i;
        wb_wreg_d  = stall_i[1] ? wb_wreg_q  : stall_i[0] ? '0 : mem_wreg_i;
        wb_wdata_d = stall_i[1] ? wb_wdata_q : stall_i[0] ? '0 : mem_wdata_i;
        wb_whilo_d = stall_i[1] ? wb_whilo_q : stall_i[0] ? '0 : mem_whilo_i;
        wb_hi_d    = stall_i[1] ? wb_hi_q    : stall_i[0] ? '0 : mem_hi_i;
        wb_lo_d    = stall_i[1] ? wb_lo_q    : stall_i[0] ? '0 : mem_lo_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rw_q    <= '0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= '0;
            wb_whilo_q <= 1'b0;
            wb_hi_q    <= '0;
            wb_lo_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            wb_rw_q    <= wb_rw_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            wb_whilo_q <= wb_whilo_d;
            wb_hi_q    <= wb_hi_d;
            wb_lo_q    <= wb_lo_d;
            if (wb_whilo_q) begin
                hi_q <= wb_hi_q;
                lo_q <= wb_lo_q;
            end
        end
    end

    // GPR contents survive reset; entry 0 is never written and never read
    always_ff @(posedge clk) begin
        if (!rst && wb_wreg_q && wb_rw_q != 5'd0) gpr_q[wb_rw_q] <= wb_wdata_q;
    end

`ifdef WB_BYPASS_EN
    assign byp1   = wb_wreg_q && raddr1_i == wb_rw_q;
    assign byp2   = wb_wreg_q && raddr2_i == wb_rw_q;
    assign byp_hl = wb_whilo_q;
`else
    assign byp1   = 1'b0;
    assign byp2   = 1'b0;
    assign byp_hl = 1'b0;
`endif

    assign rdata1_o = (rst || !re1_i || raddr1_i == 5'd0) ? '0 : byp1 ? wb_wdata_q : gpr_q[raddr1_i];
    assign rdata2_o = (rst || !re2_i || raddr2_i == 5'd0) ? '0 : byp2 ? wb_wdata_q : gpr_q[raddr2_i];
    assign hi_o     = rst ? '0 : byp_hl ? wb_hi_q : hi_q;
    assign lo_o     = rst ? '0 : byp_hl ? wb_lo_q : lo_q;

    assign wb_rw_o    = wb_rw_q;
    assign wb_wreg_o  = wb_wreg_q;
    assign wb_wdata_o = wb_wdata_q;
    assign wb_whilo_o = wb_whilo_q;
    assign wb_hi_o    = wb_hi_q;
    assign wb_lo_o    = wb_lo_q;
endmodule
